wbufifo_lvl: RTL and testbench

//  Parametrised synchronous FIFO for the debug-bus (JTAG/UART-to-wishbone)

---
 rtl/wbufifo_lvl_pkg.sv | 25 ++
 rtl/wbufifo_ram.sv | 25 ++
 rtl/wbufifo_lvl.sv | 97 +++++++++
 tb/tb_wbufifo_lvl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/wbufifo_lvl_pkg.sv
// rtl/wbufifo_lvl_pkg.sv - shared defaults and level-flag helper for debug-bus codeword FIFOs
package wbufifo_lvl_pkg;

  localparam int DEF_BW     = 36;
  localparam int DEF_LGFLEN = 6;

  typedef struct packed {
    logic empty_n;
    logic full;
    logic afull;
    logic aempty;
  } lvl_flags_t;

  // Level flags for a given fill, so every flag is derived from the same next-fill value.
  function automatic lvl_flags_t calc_flags(input int fill, input int flen,
                                            input int afull, input int aempty);
    lvl_flags_t f;
    f.empty_n = (fill != 0);
    f.full    = (fill == flen);
    f.afull   = (fill >= afull);
    f.aempty  = (fill <= aempty);
    return f;
  endfunction

endpackage

// File: rtl/wbufifo_ram.sv
// rtl/wbufifo_ram.sv - simple dual-port storage, one write port, one registered read port
module wbufifo_ram #(
  parameter int BW     = 36,
  parameter int LGFLEN = 6
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [LGFLEN-1:0] i_waddr,
  input  logic [BW-1:0]     i_wdata,
  input  logic [LGFLEN-1:0] i_raddr,
  output logic [BW-1:0]     o_rdata
);

  localparam int FLEN = 1 << LGFLEN;

  logic [BW-1:0] mem [FLEN];

  // No reset so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we)
      mem[i_waddr] <= i_wdata;
    o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/wbufifo_lvl.sv
// rtl/wbufifo_lvl.sv - first-word-fall-through codeword FIFO with fill level and sticky error flags
module wbufifo_lvl
  import wbufifo_lvl_pkg::*;
#(
  parameter int BW     = DEF_BW,
  parameter int LGFLEN = DEF_LGFLEN,
  parameter int AFULL  = 48,
  parameter int AEMPTY = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_empty_n,
  output logic              o_full,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_afull,
  output logic              o_aempty,
  output logic              o_ovfl,
  output logic              o_unfl,
  input  logic              i_clr_err
);

  localparam int FLEN = 1 << LGFLEN;
  localparam int FW   = LGFLEN + 1;

  logic [LGFLEN-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [FW-1:0]     fill_nxt;
  logic              wr_acc, rd_acc, wr_go, rd_go, byp_load;
  logic              ovfl_set, unfl_set;
  lvl_flags_t        flg_nxt;
  logic              byp_valid;
  logic [BW-1:0]     byp_data, ram_q;

  always_comb begin
    rd_acc     = i_rd && o_empty_n;
    wr_acc     = i_wr && (!o_full || rd_acc);
    rd_go      = rd_acc && !i_flush;
    wr_go      = wr_acc && !i_flush;
    ovfl_set   = i_wr && !wr_acc && !i_flush;
    unfl_set   = i_rd && !o_empty_n && !i_flush;
    // New word becomes the head directly when the RAM cannot have it ready in time.
    byp_load   = wr_go && (!o_empty_n || (o_fill == FW'(1) && rd_go));
    fill_nxt   = i_flush ? '0 : o_fill + FW'(wr_go) - FW'(rd_go);
    rd_ptr_nxt = i_flush ? '0 : rd_ptr + LGFLEN'(rd_go);
    wr_ptr_nxt = i_flush ? '0 : wr_ptr + LGFLEN'(wr_go);
    flg_nxt    = calc_flags(int'(fill_nxt), FLEN, AFULL, AEMPTY);
  end

  // Read address is the head after this edge, so the RAM output register tracks the head.
  wbufifo_ram #(.BW(BW), .LGFLEN(LGFLEN)) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_go),
    .i_waddr (wr_ptr),
    .i_wdata (i_data),
    .i_raddr (rd_ptr_nxt),
    .o_rdata (ram_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_fill    <= '0;
      o_empty_n <= 1'b0;
      o_full    <= 1'b0;
      o_afull   <= 1'b0;
      o_aempty  <= 1'b1;
      o_ovfl    <= 1'b0;
      o_unfl    <= 1'b0;
      byp_valid <= 1'b1;
      byp_data  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      o_fill    <= fill_nxt;
      o_empty_n <= flg_nxt.empty_n;
      o_full    <= flg_nxt.full;
      o_afull   <= flg_nxt.afull;
      o_aempty  <= flg_nxt.aempty;
      o_ovfl    <= (o_ovfl && !i_clr_err) || ovfl_set;
      o_unfl    <= (o_unfl && !i_clr_err) || unfl_set;
      if (byp_load) begin
        byp_valid <= 1'b1;
        byp_data  <= i_data;
      end else if (rd_go) begin
        byp_valid <= 1'b0;
      end
    end
  end

  assign o_data = byp_valid ? byp_data : ram_q;

endmodule

// File: tb/tb_wbufifo_lvl.sv
// tb/tb_wbufifo_lvl.sv - randomized and directed checks of wbufifo_lvl against a queue model
module tb_wbufifo_lvl;

  localparam int BW     = 36;
  localparam int LGFLEN = 6;
  localparam int FLEN   = 64;
  localparam int AFULL  = 48;
  localparam int AEMPTY = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_flush = 1'b0;
  logic              i_wr = 1'b0;
  logic [BW-1:0]     i_data = '0;
  logic              i_rd = 1'b0;
  logic              i_clr_err = 1'b0;
  logic [BW-1:0]     o_data;
  logic              o_empty_n, o_full, o_afull, o_aempty, o_ovfl, o_unfl;
  logic [LGFLEN:0]   o_fill;

  int                n_checks = 0;
  int                n_fail = 0;
  logic [BW-1:0]     q[$];
  logic              m_ovfl = 1'b0;
  logic              m_unfl = 1'b0;
  logic [BW-1:0]     cnt_word = '0;

  wbufifo_lvl #(.BW(BW), .LGFLEN(LGFLEN), .AFULL(AFULL), .AEMPTY(AEMPTY)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_flush   (i_flush),
    .i_wr      (i_wr),
    .i_data    (i_data),
    .i_rd      (i_rd),
    .o_data    (o_data),
    .o_empty_n (o_empty_n),
    .o_full    (o_full),
    .o_fill    (o_fill),
    .o_afull   (o_afull),
    .o_aempty  (o_aempty),
    .o_ovfl    (o_ovfl),
    .o_unfl    (o_unfl),
    .i_clr_err (i_clr_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".fill"},    64'(o_fill),    64'(n));
    check({tag, ".empty_n"}, 64'(o_empty_n), 64'(n > 0));
    check({tag, ".full"},    64'(o_full),    64'(n == FLEN));
    check({tag, ".afull"},   64'(o_afull),   64'(n >= AFULL));
    check({tag, ".aempty"},  64'(o_aempty),  64'(n <= AEMPTY));
    check({tag, ".ovfl"},    64'(o_ovfl),    64'(m_ovfl));
    check({tag, ".unfl"},    64'(o_unfl),    64'(m_unfl));
    if (n > 0)
      check({tag, ".data"}, 64'(o_data), 64'(q[0]));
  endtask

  function automatic logic [BW-1:0] rnd_word();
    logic [BW-1:0] d;
    d = {4'($urandom_range(0, 15)), 32'($urandom)};
    return d;
  endfunction

  // Called at a negedge: drive, let one rising edge pass, update model, check at next negedge.
  task automatic step(input string tag, input logic wr, input logic [BW-1:0] d,
                      input logic rd, input logic fl, input logic clr);
    int  n;
    logic rd_ok, wr_ok;
    i_wr = wr; i_data = d; i_rd = rd; i_flush = fl; i_clr_err = clr;
    @(posedge i_clk);
    n = q.size();
    if (fl) begin
      q = {};
      m_ovfl = m_ovfl && !clr;
      m_unfl = m_unfl && !clr;
    end else begin
      rd_ok = rd && (n > 0);
      wr_ok = wr && ((n < FLEN) || rd_ok);
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(d);
      m_ovfl = (m_ovfl && !clr) || (wr && !wr_ok);
      m_unfl = (m_unfl && !clr) || (rd && n == 0);
    end
    @(negedge i_clk);
    i_wr = 1'b0; i_rd = 1'b0; i_flush = 1'b0; i_clr_err = 1'b0;
    check_all(tag);
  endtask

  task automatic write_n(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step(tag, 1'b1, cnt_word, 1'b0, 1'b0, 1'b0);
      cnt_word = cnt_word + 1'b1;
    end
  endtask

  task automatic flush_model();
    step("flush", 1'b0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    #12;
    check("rst.fill",    64'(o_fill),    64'd0);
    check("rst.empty_n", 64'(o_empty_n), 64'd0);
    check("rst.aempty",  64'(o_aempty),  64'd1);
    check("rst.data",    64'(o_data),    64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_all("rst");

    // 1: single word in and out
    step("t1.wr", 1'b1, 36'hA5, 1'b0, 1'b0, 1'b0);
    check("t1.data_a5", 64'(o_data), 64'hA5);
    step("t1.rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // 2: fill to full, overflow, drain in order
    cnt_word = '0;
    write_n("t2.fill", FLEN);
    step("t2.ovfl", 1'b1, 36'hFFF, 1'b0, 1'b0, 1'b0);
    check("t2.head0", 64'(o_data), 64'd0);
    for (int i = 0; i < FLEN; i++)
      step("t2.drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("t2.clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // 3: full with rd+wr, pointer wrap over 200 words
    write_n("t3.fill", FLEN);
    for (int i = 0; i < 200; i++)
      step("t3.rdwr", 1'b1, rnd_word(), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < FLEN; i++)
      step("t3.drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // 4: underflow, rd+wr on empty, clear, clear racing a new error
    step("t4.unfl", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("t4.rdwr", 1'b1, rnd_word(), 1'b1, 1'b0, 1'b0);
    step("t4.clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step("t4.drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("t4.clrnew", 1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("t4.unfl_wins", 64'(o_unfl), 64'd1);
    step("t4.clr2", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // 5: streaming at fill 1 and fill 5
    write_n("t5.pre1", 1);
    for (int i = 0; i < 40; i++)
      step("t5.s1", 1'b1, rnd_word(), 1'b1, 1'b0, 1'b0);
    write_n("t5.pre5", 4);
    for (int i = 0; i < 40; i++)
      step("t5.s5", 1'b1, rnd_word(), 1'b1, 1'b0, 1'b0);

    // 6: flush at fill 20 with rd+wr, then async reset mid-stream
    flush_model();
    write_n("t6.fill", 20);
    step("t6.flush", 1'b1, rnd_word(), 1'b1, 1'b1, 1'b0);
    write_n("t6.refill", 10);
    #2;
    i_rst_n = 1'b0;
    #1;
    q = {}; m_ovfl = 1'b0; m_unfl = 1'b0;
    check_all("t6.arst");
    check("t6.arst_data", 64'(o_data), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step("t6.postrst", 1'b1, 36'h123456789, 1'b0, 1'b0, 1'b0);

    // random regimes biased toward filling, draining and balance
    for (int ph = 0; ph < 12; ph++) begin
      int pw, pr;
      pw = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 55;
      pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 55;
      for (int i = 0; i < 250; i++) begin
        step("rnd", 1'($urandom_range(0, 99) < pw), rnd_word(),
             1'($urandom_range(0, 99) < pr), 1'($urandom_range(0, 199) == 0),
             1'($urandom_range(0, 29) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
